// File: rtl/button_events_if.sv
// Bundle of the debounced button level and the event outputs decoded from it.
interface button_events_if;
  logic button;
  logic press;
  logic release_pulse;
  logic long_press;
  logic repeat_pulse;
  logic double_click;
  logic held;

  modport master (
    output button,
    input  press,
    input  release_pulse,
    input  long_press,
    input  repeat_pulse,
    input  double_click,
    input  held
  );

  modport slave (
    input  button,
    output press,
    output release_pulse,
    output long_press,
    output repeat_pulse,
    output double_click,
    output held
  );
endinterface

// File: rtl/button_events.sv
// Decodes a debounced button level into press/release/long-press/repeat/double-click
// events. All outputs are registered on the edge that samples the button.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// WAIT_LOW | after reset; ignore the button until it is seen low
// IDLE     | released, no double-click window open
// HELD     | pressed, counting hold cycles toward long_press
// LONG     | long press reached, counting cycles between repeat pulses
// GAP      | released after a short press, double-click window open
module button_events #(
  parameter int long_len   = 16,
  parameter int repeat_len = 4,
  parameter int double_len = 8
) (
  input logic              clk,
  input logic              reset,
  button_events_if.slave   bus
);

  localparam logic [7:0] LONG_CNT   = 8'(long_len);
  localparam logic [7:0] REPEAT_CNT = 8'(repeat_len);
  localparam logic [7:0] DOUBLE_CNT = 8'(double_len);

  typedef enum logic [2:0] {
    WAIT_LOW = 3'd0,
    IDLE     = 3'd1,
    HELD     = 3'd2,
    LONG     = 3'd3,
    GAP      = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  // Set while the current hold began as a double click; its release skips GAP.
  logic       chained, chained_nxt;

  logic press_q,  press_nxt;
  logic rel_q,    rel_nxt;
  logic long_q,   long_nxt;
  logic rpt_q,    rpt_nxt;
  logic dbl_q,    dbl_nxt;
  logic held_q,   held_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= WAIT_LOW;
      cnt     <= 8'd0;
      chained <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      rpt_q   <= 1'b0;
      dbl_q   <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      chained <= chained_nxt;
      press_q <= press_nxt;
      rel_q   <= rel_nxt;
      long_q  <= long_nxt;
      rpt_q   <= rpt_nxt;
      dbl_q   <= dbl_nxt;
      held_q  <= held_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    chained_nxt = chained;
    press_nxt   = 1'b0;
    rel_nxt     = 1'b0;
    long_nxt    = 1'b0;
    rpt_nxt     = 1'b0;
    dbl_nxt     = 1'b0;

    case (state)
      WAIT_LOW: begin
        if (!bus.button) begin
          state_nxt = IDLE;
        end
      end

      IDLE: begin
        if (bus.button) begin
          state_nxt   = HELD;
          press_nxt   = 1'b1;
          cnt_nxt     = 8'd1;
          chained_nxt = 1'b0;
        end
      end

      HELD: begin
        if (bus.button) begin
          if (cnt + 8'd1 == LONG_CNT) begin
            state_nxt = LONG;
            long_nxt  = 1'b1;
            cnt_nxt   = 8'd0;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end else begin
          // Release wins over a long_press that would land on this same edge.
          rel_nxt     = 1'b1;
          cnt_nxt     = 8'd0;
          chained_nxt = 1'b0;
          state_nxt   = chained ? IDLE : GAP;
        end
      end

      LONG: begin
        if (bus.button) begin
          if (cnt + 8'd1 == REPEAT_CNT) begin
            rpt_nxt = 1'b1;
            cnt_nxt = 8'd0;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end else begin
          rel_nxt     = 1'b1;
          cnt_nxt     = 8'd0;
          chained_nxt = 1'b0;
          state_nxt   = IDLE;
        end
      end

      GAP: begin
        if (bus.button) begin
          state_nxt = HELD;
          press_nxt = 1'b1;
          cnt_nxt   = 8'd1;
          if (cnt < DOUBLE_CNT) begin
            dbl_nxt     = 1'b1;
            chained_nxt = 1'b1;
          end
        end else if (cnt + 8'd1 == DOUBLE_CNT) begin
          state_nxt = IDLE;
          cnt_nxt   = 8'd0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end

      default: begin
        state_nxt   = WAIT_LOW;
        cnt_nxt     = 8'd0;
        chained_nxt = 1'b0;
      end
    endcase

    held_nxt = (state_nxt == HELD) || (state_nxt == LONG);
  end

  assign bus.press         = press_q;
  assign bus.release_pulse = rel_q;
  assign bus.long_press    = long_q;
  assign bus.repeat_pulse  = rpt_q;
  assign bus.double_click  = dbl_q;
  assign bus.held          = held_q;

  a_press_rel_excl: assert property (@(posedge clk) !(press_q && rel_q));
  a_long_rpt_excl:  assert property (@(posedge clk) !(long_q && rpt_q));
  a_dbl_has_press:  assert property (@(posedge clk) !dbl_q || press_q);
  a_held_matches:   assert property (@(posedge clk) held_q == ((state == HELD) || (state == LONG)));

endmodule
